// File: rtl/lane_reduce_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_pkg
// Purpose  : Shared definitions for the lane reduction accelerator: mode
//            encodings, FSM state type, constant clog2 helper and the default
//            derived lane geometry.
// Revision : 1.0 - initial release
// ============================================================================
package accel_pkg;

    // Width of the front-end data port this block sits behind.
    localparam int FE_DATA_W  = 32;
    localparam int DEF_LANE_W = 8;

    // Accumulation modes. The fourth code (2'b11) is folded onto MODE_USUM
    // when the job is latched.
    localparam logic [1:0] MODE_USUM = 2'b00;
    localparam logic [1:0] MODE_SSUM = 2'b01;
    localparam logic [1:0] MODE_UMAX = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2. clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Default geometry for the standard front-end width. Modules that take
    // their own DATA_W/LANE_W parameters derive these locally.
    localparam int NUM_LANES = FE_DATA_W / DEF_LANE_W;
    localparam int TREE_W    = DEF_LANE_W + clog2(NUM_LANES);

endpackage
`default_nettype wire

// File: rtl/lane_reduce_accel_if.sv
`default_nettype none
// ============================================================================
// Module   : lane_reduce_accel_if
// Purpose  : Job control and data stream bundle for lane_reduce_accel.
//            master : job issuer / data source
//            slave  : accelerator
// Signals  : start, mode_i, count_i          - job request (latched on start)
//            in_valid_i, in_ready_o, data_in - input beat stream
//            data_out, done, busy_o, ovf_o   - result and status
// Revision : 1.0 - initial release
// ============================================================================
interface lane_reduce_accel_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [1:0]        mode_i;
    logic [CNT_W-1:0]  count_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] data_in;
    logic [ACC_W-1:0]  data_out;
    logic              done;
    logic              busy_o;
    logic              ovf_o;

    modport master (
        output start, mode_i, count_i, in_valid_i, data_in,
        input  in_ready_o, data_out, done, busy_o, ovf_o
    );

    modport slave (
        input  start, mode_i, count_i, in_valid_i, data_in,
        output in_ready_o, data_out, done, busy_o, ovf_o
    );
endinterface
`default_nettype wire

// File: rtl/lane_reduce_accel_tree.sv
`default_nettype none
// ============================================================================
// Module   : lane_reduce_tree
// Purpose  : Combinational reduction of NUM_LANES lanes to one value.
//            Sum (lanes zero- or sign-extended) or unsigned maximum.
// Ports    : i_lanes  - packed lanes, lane i at [i*LANE_W +: LANE_W]
//            i_signed - sign-extend lanes in sum mode
//            i_max    - unsigned maximum instead of sum
//            o_result - reduced value, OUT_W bits
// Revision : 1.0 - initial release
// ============================================================================
module lane_reduce_tree #(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 4,
    parameter int OUT_W     = 10
) (
    input  wire logic [NUM_LANES*LANE_W-1:0] i_lanes,
    input  wire logic                        i_signed,
    input  wire logic                        i_max,
    output logic      [OUT_W-1:0]            o_result
);
    logic [LANE_W-1:0] w_lane;
    logic [OUT_W-1:0]  w_red;

    // OUT_W carries clog2(NUM_LANES) guard bits, so neither the unsigned
    // nor the two's-complement sum can overflow inside the tree.
    always_comb begin
        w_lane = '0;
        w_red  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lane = i_lanes[i*LANE_W +: LANE_W];
            if (i_max) begin
                if (OUT_W'(w_lane) > w_red) begin
                    w_red = OUT_W'(w_lane);
                end
            end else if (i_signed) begin
                w_red = w_red + OUT_W'($signed(w_lane));
            end else begin
                w_red = w_red + OUT_W'(w_lane);
            end
        end
    end

    assign o_result = w_red;
endmodule
`default_nettype wire

// File: rtl/lane_reduce_accel.sv
`default_nettype none
// ============================================================================
// Module   : lane_reduce_accel
// Purpose  : Per-beat lane reduction with multi-beat accumulation in
//            unsigned-sum, signed-sum or unsigned-max mode.
// Ports    : clk_i  - clock, rising edge
//            arst_i - asynchronous reset, active-high
//            bus    - job control, input stream and results (slave modport)
// Timing   : last beat accepted at edge T -> done high from T+2 to T+3,
//            data_out final by then.
// Revision : 1.0 - initial release
// ============================================================================
module lane_reduce_accel
    import accel_pkg::*;
#(
    parameter int DATA_W = FE_DATA_W,
    parameter int LANE_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic          clk_i,
    input  wire logic          arst_i,
    lane_reduce_accel_if.slave bus
);
    localparam int C_NUM_LANES = DATA_W / LANE_W;
    localparam int C_TREE_W    = LANE_W + clog2(C_NUM_LANES);

    if ((DATA_W % LANE_W) != 0 || ACC_W < C_TREE_W) begin : g_param_check
        $error("lane_reduce_accel: illegal DATA_W/LANE_W/ACC_W combination");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_mode;
    logic [CNT_W-1:0]      r_remain;
    logic [C_TREE_W-1:0]   r_s1;
    logic                  r_s1_vld;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf;

    logic                  w_ready;
    logic                  w_done;
    logic                  w_busy;
    logic                  w_start_acc;
    logic                  w_accept;
    logic [C_TREE_W-1:0]   w_tree;
    logic [ACC_W-1:0]      w_s1_ext;
    logic [ACC_W:0]        w_sum;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic                  w_ovf_step;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN holds for one cycle after the final beat with ready low; that
    // cycle plus FLUSH covers the two pipeline stages.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = (bus.count_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = (r_remain != '0);
                if (r_remain == '0) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_accept    = bus.in_valid_i && w_ready;

    // ------------------------------------------------------------------
    // Stage 1: lane reduction of the accepted beat
    // ------------------------------------------------------------------
    lane_reduce_tree #(
        .LANE_W    (LANE_W),
        .NUM_LANES (C_NUM_LANES),
        .OUT_W     (C_TREE_W)
    ) u_tree (
        .i_lanes  (bus.data_in),
        .i_signed (r_mode == MODE_SSUM),
        .i_max    (r_mode == MODE_UMAX),
        .o_result (w_tree)
    );

    // ------------------------------------------------------------------
    // Stage 2: fold into the accumulator
    // ------------------------------------------------------------------
    always_comb begin
        w_s1_ext = ACC_W'(r_s1);
        if (r_mode == MODE_SSUM) begin
            w_s1_ext = ACC_W'($signed(r_s1));
        end
        w_sum      = {1'b0, r_acc} + {1'b0, w_s1_ext};
        w_acc_nxt  = w_sum[ACC_W-1:0];
        w_ovf_step = 1'b0;
        case (r_mode)
            MODE_SSUM: begin
                // Same-sign operands yielding the opposite sign.
                w_ovf_step = (r_acc[ACC_W-1] == w_s1_ext[ACC_W-1]) &&
                             (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
            end
            MODE_UMAX: begin
                w_acc_nxt = (w_s1_ext > r_acc) ? w_s1_ext : r_acc;
            end
            default: begin
                w_ovf_step = w_sum[ACC_W];
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_mode   <= MODE_USUM;
            r_remain <= '0;
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1 <= w_tree;
            end
            if (w_start_acc) begin
                r_mode   <= (bus.mode_i == 2'b11) ? MODE_USUM : bus.mode_i;
                r_remain <= bus.count_i;
                r_acc    <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_remain <= r_remain - CNT_W'(1);
                end
                if (r_s1_vld) begin
                    r_acc <= w_acc_nxt;
                    r_ovf <= r_ovf | w_ovf_step;
                end
            end
        end
    end

    assign bus.in_ready_o = w_ready;
    assign bus.done       = w_done;
    assign bus.busy_o     = w_busy;
    assign bus.data_out   = r_acc;
    assign bus.ovf_o      = r_ovf;
endmodule
`default_nettype wire
